// File: rtl/uart_tx_arbiter_if.sv
// Bus between the byte requesters, the arbiter and the UART transmitter.
// master: arbiter side (drives acks, grant, launch, parity, status).
// slave : environment side (drives requests, request bytes/parity, UART busy).
interface uart_tx_arbiter_if #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Num_Req    = 4
);
  localparam int unsigned Id_Width = $clog2(Num_Req);

  logic [Num_Req-1:0]            Req_Valid;
  logic [Num_Req*Data_Width-1:0] Req_Data;
  logic [Num_Req-1:0]            Req_Par_En;
  logic [Num_Req-1:0]            Req_Par_Type;
  logic [Num_Req-1:0]            Req_Ack;
  logic [Id_Width-1:0]           Grant_Id;
  logic [Data_Width-1:0]         P_Data_UART;
  logic                          Data_Valid_UART;
  logic                          Par_En_UART;
  logic                          Par_Type_UART;
  logic                          Busy_UART;
  logic                          Arb_Busy;
  logic                          Timeout_Err;

  modport master (
    input  Req_Valid, Req_Data, Req_Par_En, Req_Par_Type, Busy_UART,
    output Req_Ack, Grant_Id, P_Data_UART, Data_Valid_UART, Par_En_UART,
           Par_Type_UART, Arb_Busy, Timeout_Err
  );

  modport slave (
    output Req_Valid, Req_Data, Req_Par_En, Req_Par_Type, Busy_UART,
    input  Req_Ack, Grant_Id, P_Data_UART, Data_Valid_UART, Par_En_UART,
           Par_Type_UART, Arb_Busy, Timeout_Err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among Num_Req requesters.
// A winner is picked in IDLE, launched with a one-cycle Data_Valid/Ack pulse,
// followed through the transmitter's Busy frame, then an idle guard is
// inserted before the next grant.
// Ports: clk, RST (async active-high), bus (uart_tx_arbiter_if.master):
//   requester side Req_Valid/Req_Data/Req_Par_En/Req_Par_Type -> Req_Ack,
//   UART side P_Data_UART/Data_Valid_UART/Par_En_UART/Par_Type_UART <- Busy_UART,
//   status Grant_Id, Arb_Busy, Timeout_Err. All outputs registered.
module uart_tx_arbiter #(
  parameter int unsigned Data_Width   = 8,
  parameter int unsigned Num_Req      = 4,
  parameter int unsigned Guard_Cycles = 2,
  parameter int unsigned Busy_Timeout = 16
) (
  input logic              clk,
  input logic              RST,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned ID_W   = $clog2(Num_Req);
  localparam int unsigned T_W    = $clog2(Busy_Timeout);
  // Timeout fires on the clock where the counter would step to Busy_Timeout-1.
  localparam int unsigned T_LAST = Busy_Timeout - 2;
  localparam int unsigned G_W    = (Guard_Cycles > 1) ? $clog2(Guard_Cycles) : 1;
  localparam int unsigned G_LAST = (Guard_Cycles > 0) ? Guard_Cycles - 1 : 0;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GUARD} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [T_W-1:0]        tcnt_q, tcnt_d;
  logic [G_W-1:0]        gcnt_q, gcnt_d;
  logic [Num_Req-1:0]    ack_q, ack_d;
  logic [ID_W-1:0]       gid_q, gid_d;
  logic [Data_Width-1:0] data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  pen_q, pen_d;
  logic                  ptype_q, ptype_d;
  logic                  abusy_q, abusy_d;
  logic                  terr_q, terr_d;

  logic [Data_Width-1:0] req_byte [Num_Req];
  logic                  win_found;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       cand;

  // Unpack the flat request byte bus.
  for (genvar gi = 0; gi < Num_Req; gi++) begin : g_unpack
    assign req_byte[gi] = bus.Req_Data[gi*Data_Width +: Data_Width];
  end

  // First valid requester after the pointer, with wrap-around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= Num_Req; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % Num_Req);
      if (!win_found && bus.Req_Valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    gid_d   = gid_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptype_d = ptype_q;
    ack_d   = '0;
    dv_d    = 1'b0;
    terr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A busy transmitter in IDLE belongs to someone else; hold off.
        if (win_found && !bus.Busy_UART) begin
          gid_d         = win_id;
          data_d        = req_byte[win_id];
          pen_d         = bus.Req_Par_En[win_id];
          ptype_d       = bus.Req_Par_Type[win_id];
          dv_d          = 1'b1;
          ack_d[win_id] = 1'b1;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        ptr_d   = gid_q;
        tcnt_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.Busy_UART) begin
          state_d = WAIT_DONE;
        end else if (tcnt_q == T_W'(T_LAST)) begin
          terr_d  = 1'b1;
          gcnt_d  = '0;
          state_d = (Guard_Cycles == 0) ? IDLE : GUARD;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.Busy_UART) begin
          gcnt_d  = '0;
          state_d = (Guard_Cycles == 0) ? IDLE : GUARD;
        end
      end
      GUARD: begin
        if (gcnt_q == G_W'(G_LAST)) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    abusy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(Num_Req - 1);
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      ack_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pen_q   <= 1'b0;
      ptype_q <= 1'b0;
      abusy_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pen_q   <= pen_d;
      ptype_q <= ptype_d;
      abusy_q <= abusy_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.Req_Ack         = ack_q;
  assign bus.Grant_Id        = gid_q;
  assign bus.P_Data_UART     = data_q;
  assign bus.Data_Valid_UART = dv_q;
  assign bus.Par_En_UART     = pen_q;
  assign bus.Par_Type_UART   = ptype_q;
  assign bus.Arb_Busy        = abusy_q;
  assign bus.Timeout_Err     = terr_q;

endmodule
